// File: rtl/bt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bt_pkg : packet types, payload constants and payload FSM encoding    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bt_pkg;

  typedef logic [3:0] pkt_type_t;

  localparam pkt_type_t PKT_NULL = 4'h0;
  localparam pkt_type_t PKT_POLL = 4'h1;
  localparam pkt_type_t PKT_FHS  = 4'h2;

  localparam int FHS_LEN = 144;
  localparam int CRC_LEN = 16;
  localparam int PYLEN_W = 13;

  typedef enum logic [2:0] {
    PY_IDLE    = 3'd0,
    PY_LOAD    = 3'd1,
    PY_PAYLOAD = 3'd2,
    PY_CRC     = 3'd3,
    PY_DONE    = 3'd4
  } py_state_t;

endpackage
`default_nettype wire

// File: rtl/txpyctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | txpyctrl_if : strobe, start/abort, decoder and bit-stream signals    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface txpyctrl_if;
  import bt_pkg::*;

  logic                p_1us;
  logic                tx_pystart;
  logic                tx_abort;
  logic [PYLEN_W-1:0]  pylenbit;
  logic                crcencode;
  logic                txbuf_bit;
  pkt_type_t           pk_type;
  logic [PYLEN_W-1:0]  txbuf_addr;
  logic                pybitout;
  logic                pybit_valid;
  logic                crc_phase;
  logic                py_busy;
  logic                py_endp;

  modport master (
    output p_1us, tx_pystart, tx_abort, pylenbit, crcencode, txbuf_bit,
    input  pk_type, txbuf_addr, pybitout, pybit_valid, crc_phase, py_busy, py_endp
  );

  modport slave (
    input  p_1us, tx_pystart, tx_abort, pylenbit, crcencode, txbuf_bit,
    output pk_type, txbuf_addr, pybitout, pybit_valid, crc_phase, py_busy, py_endp
  );

endinterface
`default_nettype wire

// File: rtl/txfhspack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | txfhspack : combinational assembly of the 144-bit FHS payload image  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module txfhspack
  import bt_pkg::*;
(
  input  wire logic [25:0]        clk_27_2,
  input  wire logic [2:0]         regi_FHS_LT_ADDR,
  input  wire logic [23:0]        regi_myClass,
  input  wire logic [15:0]        regi_my_BD_ADDR_NAP,
  input  wire logic [7:0]         regi_my_BD_ADDR_UAP,
  input  wire logic [1:0]         regi_SR,
  input  wire logic               regi_EIR,
  input  wire logic [23:0]        regi_my_BD_ADDR_LAP,
  input  wire logic [33:0]        regi_my_syncword,
  output logic      [FHS_LEN-1:0] fhs
);

  // Bit 0 (first on air) is the LSB of the sync word.
  assign fhs = {3'b000, clk_27_2, regi_FHS_LT_ADDR, regi_myClass,
                regi_my_BD_ADDR_NAP, regi_my_BD_ADDR_UAP, 2'b10, regi_SR,
                1'b0, regi_EIR, regi_my_BD_ADDR_LAP, regi_my_syncword};

endmodule
`default_nettype wire

// File: rtl/txpyctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | txpyctrl : TX payload sequencer - packet type, payload bits, CRC gap |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module txpyctrl
  import bt_pkg::*;
(
  input  wire logic        clk_6M,
  input  wire logic        rst,
  input  wire logic        mpr,
  input  wire logic        ir,
  input  wire logic [3:0]  regi_packet_type,
  input  wire logic [27:0] CLK,
  input  wire logic [2:0]  regi_FHS_LT_ADDR,
  input  wire logic [23:0] regi_myClass,
  input  wire logic [15:0] regi_my_BD_ADDR_NAP,
  input  wire logic [7:0]  regi_my_BD_ADDR_UAP,
  input  wire logic [1:0]  regi_SR,
  input  wire logic        regi_EIR,
  input  wire logic [23:0] regi_my_BD_ADDR_LAP,
  input  wire logic [33:0] regi_my_syncword,
  txpyctrl_if.slave        bus
);

  py_state_t           r_state;
  logic [PYLEN_W-1:0]  r_cnt;
  logic [3:0]          r_crc_cnt;
  logic [FHS_LEN-1:0]  r_fhs;
  pkt_type_t           r_pk_type;
  logic                r_pybitout;
  logic                r_pybit_valid;
  logic                r_crc_phase;
  logic                r_py_busy;
  logic                r_py_endp;

  logic [FHS_LEN-1:0]  w_fhs;
  logic                w_fhs_bit;
  logic                w_src_bit;
  logic                w_last_bit;
  logic                w_crc_last;
  logic                w_unused_clk_lsb;

  txfhspack u_fhspack (
    .clk_27_2            (CLK[27:2]),
    .regi_FHS_LT_ADDR    (regi_FHS_LT_ADDR),
    .regi_myClass        (regi_myClass),
    .regi_my_BD_ADDR_NAP (regi_my_BD_ADDR_NAP),
    .regi_my_BD_ADDR_UAP (regi_my_BD_ADDR_UAP),
    .regi_SR             (regi_SR),
    .regi_EIR            (regi_EIR),
    .regi_my_BD_ADDR_LAP (regi_my_BD_ADDR_LAP),
    .regi_my_syncword    (regi_my_syncword),
    .fhs                 (w_fhs)
  );

  assign w_unused_clk_lsb = ^CLK[1:0];

  // Oversized FHS payloads pad with zeros past the 144-bit image.
  assign w_fhs_bit  = (r_cnt < PYLEN_W'(FHS_LEN)) ? r_fhs[r_cnt[7:0]] : 1'b0;
  assign w_src_bit  = (r_pk_type == PKT_FHS) ? w_fhs_bit : bus.txbuf_bit;
  assign w_last_bit = (r_cnt == (bus.pylenbit - PYLEN_W'(1)));
  assign w_crc_last = (r_crc_cnt == 4'(CRC_LEN - 1));

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      r_state       <= PY_IDLE;
      r_cnt         <= '0;
      r_crc_cnt     <= '0;
      r_fhs         <= '0;
      r_pk_type     <= PKT_NULL;
      r_pybitout    <= 1'b0;
      r_pybit_valid <= 1'b0;
      r_crc_phase   <= 1'b0;
      r_py_busy     <= 1'b0;
      r_py_endp     <= 1'b0;
    end else begin
      r_pybit_valid <= 1'b0;
      r_py_endp     <= 1'b0;
      if (bus.tx_abort) begin
        r_state     <= PY_IDLE;
        r_py_busy   <= 1'b0;
        r_crc_phase <= 1'b0;
      end else begin
        case (r_state)
          PY_IDLE: begin
            if (bus.tx_pystart) begin
              r_pk_type <= (mpr | ir) ? PKT_FHS : regi_packet_type;
              r_state   <= PY_LOAD;
              r_py_busy <= 1'b1;
            end
          end
          PY_LOAD: begin
            r_fhs     <= w_fhs;
            r_cnt     <= '0;
            r_crc_cnt <= '0;
            if (bus.pylenbit != '0) begin
              r_state <= PY_PAYLOAD;
            end else if (bus.crcencode) begin
              r_state <= PY_CRC;
            end else begin
              r_state   <= PY_DONE;
              r_py_endp <= 1'b1;
            end
          end
          PY_PAYLOAD: begin
            if (bus.p_1us) begin
              r_pybitout    <= w_src_bit;
              r_pybit_valid <= 1'b1;
              r_cnt         <= r_cnt + PYLEN_W'(1);
              if (w_last_bit) begin
                if (bus.crcencode) begin
                  r_state <= PY_CRC;
                end else begin
                  r_state   <= PY_DONE;
                  r_py_endp <= 1'b1;
                end
              end
            end
          end
          PY_CRC: begin
            // The CRC unit downstream substitutes the real check bits.
            if (bus.p_1us) begin
              r_pybitout    <= 1'b0;
              r_pybit_valid <= 1'b1;
              r_crc_phase   <= 1'b1;
              r_crc_cnt     <= r_crc_cnt + 4'd1;
              if (w_crc_last) begin
                r_state   <= PY_DONE;
                r_py_endp <= 1'b1;
              end
            end
          end
          PY_DONE: begin
            r_state     <= PY_IDLE;
            r_py_busy   <= 1'b0;
            r_crc_phase <= 1'b0;
          end
          default: begin
            r_state     <= PY_IDLE;
            r_py_busy   <= 1'b0;
            r_crc_phase <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pk_type     = r_pk_type;
  assign bus.txbuf_addr  = r_cnt;
  assign bus.pybitout    = r_pybitout;
  assign bus.pybit_valid = r_pybit_valid;
  assign bus.crc_phase   = r_crc_phase;
  assign bus.py_busy     = r_py_busy;
  assign bus.py_endp     = r_py_endp;

endmodule
`default_nettype wire
